rs_align_seq: RTL and testbench

// - Sequential right-shift mantissa aligner for the IEEE754 double-precision datapath.
// - Counterpart of the fixed left-shift-by-2 normaliser: shifts a 64-bit operand right by a runtime amount, STEP bits per cycle.
// - Accumulates a sticky bit from every bit shifted out, for round-to-nearest.
// - Sits ahead of the add/sub stage; aligns the smaller-exponent mantissa by the exponent difference.

---
 rtl/rs_align_seq.sv | 110 +++++++++++
 tb/tb_rs_align_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rs_align_seq.sv
// Sequential right-shift mantissa aligner: shifts din right by shamt, STEP bits per cycle,
// collecting a sticky bit from everything shifted out.
module rs_align_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned STEP  = 2,
    parameter int unsigned SHW   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             sticky
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [SHW-1:0] StepAmt = SHW'(STEP);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             sticky_q;
    logic [SHW-1:0]   rem_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [SHW-1:0]   step_amt;
    logic [WIDTH-1:0] drop_mask;
    logic [WIDTH-1:0] data_shr;
    logic             accept;
    logic             saturate;

    always_comb begin
        step_amt  = (rem_q < StepAmt) ? rem_q : StepAmt;
        // Selects exactly the step_amt LSBs that fall off this cycle.
        drop_mask = ~({WIDTH{1'b1}} << step_amt);
        data_shr  = data_q >> step_amt;
        accept    = in_valid & in_ready_q;
        saturate  = 32'(shamt) >= WIDTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            sticky_q    <= 1'b0;
            rem_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (shamt == '0) begin
                            data_q      <= din;
                            sticky_q    <= 1'b0;
                            rem_q       <= '0;
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else if (saturate) begin
                            // Whole operand falls out: no point spending cycles on it.
                            data_q      <= '0;
                            sticky_q    <= |din;
                            rem_q       <= '0;
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            data_q   <= din;
                            sticky_q <= 1'b0;
                            rem_q    <= shamt;
                            state_q  <= StShift;
                        end
                    end
                end
                StShift: begin
                    data_q   <= data_shr;
                    sticky_q <= sticky_q | (|(data_q & drop_mask));
                    rem_q    <= rem_q - step_amt;
                    if (rem_q == step_amt) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = data_q;
    assign sticky    = sticky_q;

endmodule

// File: tb/tb_rs_align_seq.sv
// Bench for rs_align_seq: directed operands with literal expectations, plus a
// transaction-level model checked against the outputs on every falling edge.
module tb_rs_align_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] din = '0;
    logic [6:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] dout;
    logic        sticky;

    int vectors = 0;
    int fails   = 0;

    rs_align_seq #(.WIDTH(64), .STEP(2), .SHW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Result of a logical right shift with sticky, straight from the arithmetic definition.
    function automatic logic [64:0] ref_shift(input logic [63:0] d, input int sh);
        if (sh >= 64) return {64'h0, |d};
        return {d >> sh, |(d << (64 - sh))};
    endfunction

    function automatic int ref_lat(input int sh);
        if (sh == 0 || sh >= 64) return 0;
        return (sh + 1) / 2;
    endfunction

    // Transaction model: busy from acceptance until the result is taken.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    logic [63:0] m_dout = '0;
    logic        m_sticky = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_cnt    <= 0;
            m_dout   <= '0;
            m_sticky <= 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy   <= 1'b1;
                m_cnt    <= ref_lat(int'(shamt));
                m_done   <= (ref_lat(int'(shamt)) == 0);
                {m_dout, m_sticky} <= ref_shift(din, int'(shamt));
            end
        end else if (!m_done) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_done <= 1'b1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
            chk("rst_dout", dout, 64'h0);
            chk("rst_sticky", {63'h0, sticky}, 64'h0);
        end else begin
            chk("mdl_in_ready", {63'h0, in_ready}, {63'h0, !m_busy});
            chk("mdl_out_valid", {63'h0, out_valid}, {63'h0, m_done});
            if (m_done) begin
                chk("mdl_dout", dout, m_dout);
                chk("mdl_sticky", {63'h0, sticky}, {63'h0, m_sticky});
            end
        end
    end

    task automatic run_op(input logic [63:0] d, input logic [6:0] sh, input logic [63:0] exp_d,
                          input logic exp_s, input int exp_n, input int hold);
        int edges;
        @(negedge clk);
        chk("accept_ready", {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        din      = d;
        shamt    = sh;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = {$urandom, $urandom};
        shamt    = 7'($urandom_range(0, 127));
        edges    = 0;
        while (!out_valid && edges < 200) begin
            // A stray in_valid while busy must be ignored.
            in_valid = (edges == 1);
            @(posedge clk);
            #1;
            edges++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(edges), 64'(exp_n));
        chk("dout", dout, exp_d);
        chk("sticky", {63'h0, sticky}, {63'h0, exp_s});
        repeat (hold) @(posedge clk);
        #1;
        chk("held_dout", dout, exp_d);
        chk("held_in_ready", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("leave_out_valid", {63'h0, out_valid}, 64'h0);
        chk("leave_in_ready", {63'h0, in_ready}, 64'h1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("reset_in_ready", {63'h0, in_ready}, 64'h1);

        run_op(64'hF, 7'd2, 64'h3, 1'b1, 1, 0);
        run_op(64'hF, 7'd3, 64'h1, 1'b1, 2, 0);
        run_op(64'h8000_0000_0000_0000, 7'd63, 64'h1, 1'b0, 32, 0);
        run_op(64'hA5, 7'd0, 64'hA5, 1'b0, 0, 0);
        run_op(64'h1, 7'd70, 64'h0, 1'b1, 0, 0);
        run_op(64'hF0, 7'd4, 64'hF, 1'b0, 2, 3);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 64'h0, 1'b1, 0, 0);
        run_op(64'h0, 7'd127, 64'h0, 1'b0, 0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 7'd63, 64'h1, 1'b1, 32, 0);
        run_op(64'h1, 7'd1, 64'h0, 1'b1, 1, 0);
        run_op(64'h8000_0000_0000_0001, 7'd5, 64'h0400_0000_0000_0000, 1'b1, 3, 10);
        run_op(64'h0000_0000_0000_0100, 7'd8, 64'h1, 1'b0, 4, 0);

        // Abandon an operation mid-shift.
        @(negedge clk);
        in_valid = 1'b1;
        din      = 64'hFF;
        shamt    = 7'd40;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("midshift_busy", {63'h0, in_ready}, 64'h0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", {63'h0, out_valid}, 64'h0);
        chk("abort_dout", dout, 64'h0);
        chk("abort_sticky", {63'h0, sticky}, 64'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("abort_in_ready", {63'h0, in_ready}, 64'h1);
        repeat (3) @(posedge clk);
        #1 chk("abort_no_result", {63'h0, out_valid}, 64'h0);

        run_op(64'h0000_0000_0000_0007, 7'd2, 64'h1, 1'b1, 1, 2);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
